wb_write_sequencer: RTL and testbench
=====================================

Name: wb_write_sequencer

Overview:
- Sits between the MEM/WB pipeline register outputs and the single-write-port register file.
- Instructions writing two destinations (reg_a plus reg_b, e.g. LO/HI results) are serialized over two cycles. While that happens, the block stalls the pipeline by driving the MEM/WB enable and the upstream stall.
- It also selects the write-back source (memory or ALU), suppresses writes to r0 and counts serialization stalls.

Parameters:
- DATA_WIDTH, 32, register data width
- REG_ADDR_WIDTH, 5, register address width
- CNT_WIDTH, 16, stall counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- hold_in  in  1  global pipeline hold (e.g. data-memory wait)
- write_back_mux_sel_in  in  1  1 = mem_data_in, 0 = alu_data_in for port A
- alu_data_in  in  DATA_WIDTH  ALU result (port A source)
- mem_data_in  in  DATA_WIDTH  load data (port A source)
- hi_data_in  in  DATA_WIDTH  port B data
- reg_a_wr_addr_in  in  REG_ADDR_WIDTH  port A destination
- reg_b_wr_addr_in  in  REG_ADDR_WIDTH  port B destination
- reg_a_wr_en_in  in  1  port A write request
- reg_b_wr_en_in  in  1  port B write request
- rf_wr_en  out  1  register file write enable
- rf_wr_addr  out  REG_ADDR_WIDTH  register file write address
- rf_wr_data  out  DATA_WIDTH  register file write data
- mem_wb_en  out  1  enable for the MEM/WB register
- stall_out  out  1  stall request to earlier stages
- stall_count  out  CNT_WIDTH  number of serialization stall cycles

Behaviour:
- Single clock domain. All state updates on posedge clk. Reset is synchronous and active-low: when rst_n is 0 at a clock edge, state goes to IDLE and stall_count to 0.
- During reset, outputs are combinational from state IDLE with request gating:
  - rf_wr_en = 0, rf_wr_addr = 0, rf_wr_data = 0, stall_out = 0, mem_wb_en = 1.
  - Requests are masked while rst_n is 0.
- Effective requests:
  - a_v = reg_a_wr_en_in & (reg_a_wr_addr_in != 0)
  - b_v = reg_b_wr_en_in & (reg_b_wr_addr_in != 0)
  - Same-address rule: if a_v, b_v and the addresses are equal, drop a_v. B is architecturally last, so only one write occurs and there is no stall.
- Port A data is mem_data_in if write_back_mux_sel_in is 1, else alu_data_in.
- FSM states: IDLE, SECOND.
- IDLE behaviour:
  - Only a_v: write A (rf_wr_en = 1, address/data of A).
  - Only b_v: write B.
  - Neither: rf_wr_en = 0 and addr/data = 0.
  - Both: write A, assert stall_out = 1 and mem_wb_en = 0, then go to SECOND.
- SECOND behaviour:
  - Write B (the MEM/WB register still holds the same instruction because its enable was low).
  - stall_out = 0, mem_wb_en = 1, next state IDLE.
- mem_wb_en outside the dual-write case is ~hold_in; in the dual-write IDLE cycle it is 0.
- hold_in = 1 has priority over everything:
  - rf_wr_en = 0, stall_out = 0 (hold is already global), mem_wb_en = 0.
  - State and stall_count are frozen. The write resumes when hold drops, so each write happens exactly once.
- stall_count increments by 1 in every IDLE-to-SECOND transition. It saturates at all-ones and does not wrap.
- Latency: writes are combinational in the cycle the request is visible. A dual write occupies 2 cycles.
- Reset during SECOND: state returns to IDLE and the pending B write is discarded.
- Outputs are combinational from state and inputs. There are no other registers besides state and the counter.

Decomposition:
- The shared pipeline package holds the FSM state encoding (WB_IDLE = 1'b0, WB_SECOND = 1'b1) and the REG_ZERO address constant, 0.
- No sub-module, except an optional saturating counter, sat_counter (parameter WIDTH), reusable for other performance counters.

Test Plan:
- Single A write:
  - Stimulus: a_en = 1, a_addr = 3, alu = 0x11, sel = 0.
  - Response: rf_wr_en = 1, addr 3, data 0x11; stall_out = 0, mem_wb_en = 1; one cycle; stall_count = 0.
- Load write:
  - Stimulus: sel = 1, mem_data = 0xDEAD, a_addr = 7.
  - Response: data 0xDEAD written to 7.
- Dual write:
  - Stimulus: a_addr = 4 / alu = 0xA, b_addr = 5 / hi = 0xB.
  - Cycle 1 response: write 4 = 0xA, stall_out = 1, mem_wb_en = 0.
  - Cycle 2 response: write 5 = 0xB, stall_out = 0.
  - stall_count = 1.
- r0 and same-address handling:
  - Stimulus: a_addr = 0 with b_addr = 6 -> only write 6, no stall.
  - Stimulus: a_addr = b_addr = 9 -> only hi data to 9, no stall.
- Hold during SECOND:
  - Stimulus: hold_in = 1 for 3 cycles in SECOND.
  - Response: rf_wr_en = 0 and mem_wb_en = 0 throughout; after release, B is written once and the FSM returns to IDLE.
- Reset:
  - Stimulus: rst_n = 0 in SECOND.
  - Response: at the next edge, IDLE and stall_count = 0; no B write afterwards.
  - Saturation: preload 0xFFFF via repeated dual writes (or force) -> count stays 0xFFFF.

Source files
------------

// File: rtl/wb_write_sequencer_pkg.sv
// Shared pipeline definitions for the write-back sequencer.
//   wb_state_e : write-back FSM state encoding
//   REG_ZERO   : architectural zero register address (writes discarded)
package wb_write_sequencer_pkg;

   typedef enum logic {
      WB_IDLE   = 1'b0,
      WB_SECOND = 1'b1
   } wb_state_e;

   localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_write_sequencer_sat_counter.sv
// Saturating up-counter for performance statistics.
//   clk, rst_n : clock, synchronous active-low clear
//   inc        : add one this cycle (ignored once all-ones)
//   count      : current value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n)
         count <= '0;
      else if (inc && (count != {WIDTH{1'b1}}))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/wb_write_sequencer.sv
// Write-back sequencer between the MEM/WB register and a single-port
// register file. Dual-destination instructions (A then B) are serialized
// over two cycles while the MEM/WB register and upstream are stalled.
//   clk, rst_n               : clock, synchronous active-low reset
//   hold_in                  : global pipeline hold, freezes everything
//   write_back_mux_sel_in    : port A source, 1 = memory, 0 = ALU
//   alu/mem/hi_data_in       : A sources and B data
//   reg_a/b_wr_addr/en_in    : destination requests
//   rf_wr_en/addr/data       : register file write port
//   mem_wb_en, stall_out     : pipeline control
//   stall_count              : saturating count of serialization stalls
module wb_write_sequencer
   import wb_write_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      hold_in,
   input  logic                      write_back_mux_sel_in,
   input  logic [DATA_WIDTH-1:0]     alu_data_in,
   input  logic [DATA_WIDTH-1:0]     mem_data_in,
   input  logic [DATA_WIDTH-1:0]     hi_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr_in,
   input  logic                      reg_a_wr_en_in,
   input  logic                      reg_b_wr_en_in,
   output logic                      rf_wr_en,
   output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
   output logic [DATA_WIDTH-1:0]     rf_wr_data,
   output logic                      mem_wb_en,
   output logic                      stall_out,
   output logic [CNT_WIDTH-1:0]      stall_count
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_ADDR = REG_ADDR_WIDTH'(REG_ZERO);

   wb_state_e state, state_nxt;
   logic      a_v, b_v, a_eff, dual_start;
   logic [DATA_WIDTH-1:0] a_data;

   // Requests are masked during reset; r0 writes never reach the file.
   assign a_v    = rst_n & reg_a_wr_en_in & (reg_a_wr_addr_in != ZERO_ADDR);
   assign b_v    = rst_n & reg_b_wr_en_in & (reg_b_wr_addr_in != ZERO_ADDR);
   // Same destination: B is architecturally last, so A is simply dropped.
   assign a_eff  = a_v & ~(b_v & (reg_a_wr_addr_in == reg_b_wr_addr_in));
   assign a_data = write_back_mux_sel_in ? mem_data_in : alu_data_in;

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= WB_IDLE;
      else if (!hold_in)
         state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      rf_wr_en   = 1'b0;
      rf_wr_addr = '0;
      rf_wr_data = '0;
      stall_out  = 1'b0;
      mem_wb_en  = ~hold_in;
      dual_start = 1'b0;
      if (!rst_n) begin
         state_nxt = WB_IDLE;
         mem_wb_en = 1'b1;
      end else if (!hold_in) begin
         case (state)
            WB_IDLE: begin
               if (a_eff) begin
                  rf_wr_en   = 1'b1;
                  rf_wr_addr = reg_a_wr_addr_in;
                  rf_wr_data = a_data;
                  if (b_v) begin
                     // Keep MEM/WB loaded so B is still presented next cycle.
                     stall_out  = 1'b1;
                     mem_wb_en  = 1'b0;
                     dual_start = 1'b1;
                     state_nxt  = WB_SECOND;
                  end
               end else if (b_v) begin
                  rf_wr_en   = 1'b1;
                  rf_wr_addr = reg_b_wr_addr_in;
                  rf_wr_data = hi_data_in;
               end
            end
            WB_SECOND: begin
               rf_wr_en   = b_v;
               rf_wr_addr = reg_b_wr_addr_in;
               rf_wr_data = hi_data_in;
               state_nxt  = WB_IDLE;
            end
            default: state_nxt = WB_IDLE;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (dual_start),
      .count (stall_count)
   );

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Bench for wb_write_sequencer: directed vectors with literal expectations
// plus a per-cycle comparison against a behavioural model.
module tb_wb_write_sequencer;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int CW = 4;  // narrow counter so saturation is reachable quickly
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hold_in = 1'b0;
   logic          sel = 1'b0;
   logic [DW-1:0] alu = '0, mem = '0, hi = '0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic          a_en = 1'b0, b_en = 1'b0;
   logic          rf_wr_en, mem_wb_en, stall_out;
   logic [AW-1:0] rf_wr_addr;
   logic [DW-1:0] rf_wr_data;
   logic [CW-1:0] stall_count;

   int checks = 0;
   int errors = 0;

   // Model state: is a B write still owed, and how many stalls so far.
   bit m_pend = 1'b0;
   int m_cnt = 0;

   wb_write_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .hold_in(hold_in),
      .write_back_mux_sel_in(sel), .alu_data_in(alu), .mem_data_in(mem),
      .hi_data_in(hi), .reg_a_wr_addr_in(a_addr), .reg_b_wr_addr_in(b_addr),
      .reg_a_wr_en_in(a_en), .reg_b_wr_en_in(b_en),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .mem_wb_en(mem_wb_en), .stall_out(stall_out), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          stall;
      logic          mwb;
   } exp_t;

   function automatic bit is_dual();
      return a_en && a_addr != 0 && b_en && b_addr != 0 && a_addr != b_addr;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e = '{en: 1'b0, addr: '0, data: '0, stall: 1'b0, mwb: 1'b1};
      if (!rst_n) return e;
      if (hold_in) begin e.mwb = 1'b0; return e; end
      if (m_pend) begin
         e.en = 1'b1; e.addr = b_addr; e.data = hi;
      end else if (is_dual()) begin
         e.en = 1'b1; e.addr = a_addr; e.data = sel ? mem : alu;
         e.stall = 1'b1; e.mwb = 1'b0;
      end else if (b_en && b_addr != 0) begin
         e.en = 1'b1; e.addr = b_addr; e.data = hi;
      end else if (a_en && a_addr != 0) begin
         e.en = 1'b1; e.addr = a_addr; e.data = sel ? mem : alu;
      end
      return e;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pend <= 1'b0;
         m_cnt  <= 0;
      end else if (!hold_in) begin
         if (m_pend)
            m_pend <= 1'b0;
         else if (is_dual()) begin
            m_pend <= 1'b1;
            if (m_cnt < CMAX) m_cnt <= m_cnt + 1;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      e = model_out();
      chk("m_wr_en", 64'(rf_wr_en), 64'(e.en));
      if (e.en) begin
         chk("m_wr_addr", 64'(rf_wr_addr), 64'(e.addr));
         chk("m_wr_data", 64'(rf_wr_data), 64'(e.data));
      end
      chk("m_stall", 64'(stall_out), 64'(e.stall));
      chk("m_mem_wb_en", 64'(mem_wb_en), 64'(e.mwb));
      chk("m_stall_count", 64'(stall_count), 64'(m_cnt));
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic ae, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic be, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      a_en = ae; a_addr = aa; alu = ad; b_en = be; b_addr = ba; hi = bd;
   endtask

   task automatic idle_req();
      req(1'b0, '0, '0, 1'b0, '0, '0);
      sel = 1'b0;
   endtask

   task automatic lit(input string nm, input logic en, input logic [AW-1:0] ad,
                      input logic [DW-1:0] dt, input logic st, input logic mw);
      @(negedge clk);
      #1;
      chk({nm, "_en"}, 64'(rf_wr_en), 64'(en));
      if (en) begin
         chk({nm, "_addr"}, 64'(rf_wr_addr), 64'(ad));
         chk({nm, "_data"}, 64'(rf_wr_data), 64'(dt));
      end
      chk({nm, "_stall"}, 64'(stall_out), 64'(st));
      chk({nm, "_mwb"}, 64'(mem_wb_en), 64'(mw));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with a live request: it must be masked.
      req(1'b1, 5'd3, 32'h11, 1'b0, '0, '0);
      nxt(); nxt();
      lit("reset", 1'b0, '0, '0, 1'b0, 1'b1);
      chk("reset_count", 64'(stall_count), 64'd0);
      rst_n = 1'b1;

      // Single A write from ALU.
      lit("single_a", 1'b1, 5'd3, 32'h11, 1'b0, 1'b1);
      chk("single_a_count", 64'(stall_count), 64'd0);
      nxt(); idle_req();
      lit("idle", 1'b0, '0, '0, 1'b0, 1'b1);

      // Load write selects memory data.
      nxt(); sel = 1'b1; mem = 32'hDEAD; req(1'b1, 5'd7, 32'h55, 1'b0, '0, '0);
      lit("load", 1'b1, 5'd7, 32'hDEAD, 1'b0, 1'b1);

      // Dual write: A then B with one stall.
      nxt(); idle_req(); req(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB);
      lit("dual_c1", 1'b1, 5'd4, 32'hA, 1'b1, 1'b0);
      nxt();
      lit("dual_c2", 1'b1, 5'd5, 32'hB, 1'b0, 1'b1);
      chk("dual_count", 64'(stall_count), 64'd1);
      nxt(); idle_req();

      // r0 on A: only B written, no stall.
      req(1'b1, 5'd0, 32'h77, 1'b1, 5'd6, 32'h66);
      lit("r0_a", 1'b1, 5'd6, 32'h66, 1'b0, 1'b1);
      // Same address: only hi data, no stall.
      nxt(); req(1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 32'h55);
      lit("same_addr", 1'b1, 5'd9, 32'h55, 1'b0, 1'b1);
      nxt(); idle_req();
      lit("same_addr_after", 1'b0, '0, '0, 1'b0, 1'b1);
      chk("same_addr_count", 64'(stall_count), 64'd1);

      // Hold for three cycles in SECOND.
      nxt(); req(1'b1, 5'd10, 32'h1, 1'b1, 5'd11, 32'h2);
      lit("hold_c1", 1'b1, 5'd10, 32'h1, 1'b1, 1'b0);
      nxt(); hold_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         lit("hold", 1'b0, '0, '0, 1'b0, 1'b0);
         nxt();
      end
      hold_in = 1'b0;
      lit("hold_release", 1'b1, 5'd11, 32'h2, 1'b0, 1'b1);
      chk("hold_count", 64'(stall_count), 64'd2);
      nxt(); idle_req();
      lit("hold_after", 1'b0, '0, '0, 1'b0, 1'b1);

      // Reset while in SECOND drops the pending B write.
      nxt(); req(1'b1, 5'd12, 32'h3, 1'b1, 5'd13, 32'h4);
      lit("rst2_c1", 1'b1, 5'd12, 32'h3, 1'b1, 1'b0);
      nxt(); rst_n = 1'b0;
      lit("rst2_in_reset", 1'b0, '0, '0, 1'b0, 1'b1);
      nxt(); idle_req();
      chk("rst2_count", 64'(stall_count), 64'd0);
      rst_n = 1'b1;
      lit("rst2_no_b", 1'b0, '0, '0, 1'b0, 1'b1);

      // Saturation: more dual writes than the counter can hold.
      for (int i = 0; i < CMAX + 2; i++) begin
         nxt(); req(1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'(i + 100));
         nxt(); nxt(); idle_req();
      end
      lit("sat_idle", 1'b0, '0, '0, 1'b0, 1'b1);
      chk("sat_count", 64'(stall_count), 64'hF);

      nxt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
